ir_cmd_encoder: RTL and testbench

IR_CMD_ENCODER -- requirements
Module: ir_cmd_encoder

---
 rtl/ir_cmd_encoder_pkg.sv | 48 ++++
 rtl/ir_cmd_encoder_if.sv | 39 +++
 rtl/ir_cmd_encoder_uart_tx_byte.sv | 59 +++++
 rtl/ir_cmd_encoder.sv | 167 ++++++++++++++++
 tb/tb_ir_cmd_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ir_cmd_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_cmd_pkg
// Description : Shared definitions for the IR command encoder. Includes the
//               command codes, the header sync bits, the packet byte counts
//               (plain and with checksum), the packet FSM state type and a
//               helper that builds the header byte.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_cmd_pkg;

    localparam int CMD_W  = 3;
    localparam int ADDR_W = 3;
    localparam int ARG_W  = 8;

    typedef enum logic [CMD_W-1:0] {
        CMD_RESET    = 3'd0,
        CMD_RST_DAC  = 3'd1,
        CMD_INC_DAC  = 3'd2,
        CMD_DEV_SEL  = 3'd3,
        CMD_RST_TEST = 3'd4,
        CMD_STARTUP  = 3'd5,
        CMD_READ     = 3'd6,
        CMD_RESERVED = 3'd7
    } cmd_e;

    // Fixed leading bits of every header byte.
    localparam logic [1:0] HDR_SYNC = 2'b10;

    // Bytes per packet: header + argument, plus an optional XOR checksum byte.
    localparam int PKT_BYTES_BASE = 2;
    localparam int PKT_BYTES_CSUM = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_NEXT  = 3'd4
    } state_e;

    function automatic logic [7:0] make_header(input logic [CMD_W-1:0]  cmd,
                                               input logic [ADDR_W-1:0] dev_addr);
        return {HDR_SYNC, cmd, dev_addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_cmd_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ir_cmd_encoder_if
// Description : Command request handshake between a requester (master) and
//               the IR command encoder (slave).
//               req_valid    : request present            (master -> slave)
//               req_ready    : encoder can accept         (slave  -> master)
//               req_cmd      : 3-bit command code         (master -> slave)
//               req_dev_addr : 3-bit target device        (master -> slave)
//               req_arg      : 8-bit argument byte        (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_cmd_encoder_if;
    import ir_cmd_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [ADDR_W-1:0] req_dev_addr;
    logic [ARG_W-1:0]  req_arg;

    modport master (
        output req_valid,
        output req_cmd,
        output req_dev_addr,
        output req_arg,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_dev_addr,
        input  req_arg,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/ir_cmd_encoder_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 bit serialiser, LSB first, idle high. A load pulse starts
//               a new frame immediately (start bit driven from the next
//               cycle), even if the previous stop bit is in its last cycle.
//               clk / rst          : clock, synchronous active-high reset
//               load_i, byte_i     : start a frame carrying byte_i
//               tx_o               : serial output (registered)
//               bit_done_o         : current bit is in its final cycle
//               bit_pre_done_o     : current bit is in its next-to-final cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       load_i,
    input  wire logic [7:0] byte_i,
    output logic            tx_o,
    output logic            bit_done_o,
    output logic            bit_pre_done_o
);

    localparam int              c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_PRE  = c_CNT_W'(CLKS_PER_BIT - 2);

    logic [c_CNT_W-1:0] cnt_q;
    logic [8:0]         shift_q;   // remaining bits: data then stop, ones fill behind
    logic               tx_q;

    // The counter free-runs between frames; a load realigns it, so every bit
    // boundary of a frame is measured from the load and never drifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '1;
            tx_q    <= 1'b1;
        end else if (load_i) begin
            cnt_q   <= '0;
            shift_q <= {1'b1, byte_i};
            tx_q    <= 1'b0;
        end else if (cnt_q == c_LAST) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[8:1]};
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign tx_o           = tx_q;
    assign bit_done_o     = (cnt_q == c_LAST);
    assign bit_pre_done_o = (cnt_q == c_PRE);

endmodule
`default_nettype wire

// File: rtl/ir_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ir_cmd_encoder
// Description : Encodes a command request into a UART packet: header byte
//               {2'b10, cmd, dev_addr} followed by the argument byte. When
//               the macro IR_CMD_ENC_CHECKSUM_EN is defined a third byte,
//               header XOR argument, is appended.
//               clk / rst : clock, synchronous active-high reset
//               req       : request handshake (ir_cmd_encoder_if.slave)
//               tx        : UART 8N1 serial output, idle high
//               busy      : packet in progress
//               done      : one-cycle pulse after the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module ir_cmd_encoder
    import ir_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ir_cmd_encoder_if.slave  req,
    output logic             tx,
    output logic             busy,
    output logic             done
);

`ifdef IR_CMD_ENC_CHECKSUM_EN
    localparam int c_NUM_BYTES = PKT_BYTES_CSUM;
`else
    localparam int c_NUM_BYTES = PKT_BYTES_BASE;
`endif
    localparam logic [1:0] c_LAST_IDX = 2'(c_NUM_BYTES - 1);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [7:0] arg_q, arg_d;
    logic       done_q, done_d;
`ifdef IR_CMD_ENC_CHECKSUM_EN
    logic [7:0] hdr_q, hdr_d;
`endif

    logic       w_ready;
    logic       w_load;
    logic [7:0] w_load_byte;
    logic       w_bit_done;
    logic       w_bit_pre_done;

    // Ready is low while rst is held and rises as soon as rst drops.
    assign w_ready = (state_q == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            arg_q      <= '0;
            done_q     <= 1'b0;
`ifdef IR_CMD_ENC_CHECKSUM_EN
            hdr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            arg_q      <= arg_d;
            done_q     <= done_d;
`ifdef IR_CMD_ENC_CHECKSUM_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_idx_d  = byte_idx_q;
        arg_d       = arg_q;
        done_d      = 1'b0;
        w_load      = 1'b0;
        w_load_byte = arg_q;
`ifdef IR_CMD_ENC_CHECKSUM_EN
        hdr_d       = hdr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req.req_valid && w_ready) begin
                    // The header goes straight into the serialiser; only the
                    // bytes sent later need to be held here.
                    w_load      = 1'b1;
                    w_load_byte = make_header(req.req_cmd, req.req_dev_addr);
                    arg_d       = req.req_arg;
`ifdef IR_CMD_ENC_CHECKSUM_EN
                    hdr_d       = make_header(req.req_cmd, req.req_dev_addr);
`endif
                    byte_idx_d  = 2'd0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // NEXT occupies the final cycle of the stop bit, so deciding
                // on the next byte costs no extra tx time.
                if (w_bit_pre_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (w_bit_done) begin
                    if (byte_idx_q == c_LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        w_load     = 1'b1;
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_START;
`ifdef IR_CMD_ENC_CHECKSUM_EN
                        if (byte_idx_q == 2'd0) begin
                            w_load_byte = arg_q;
                        end else begin
                            w_load_byte = hdr_q ^ arg_q;
                        end
`else
                        w_load_byte = arg_q;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk            (clk),
        .rst            (rst),
        .load_i         (w_load),
        .byte_i         (w_load_byte),
        .tx_o           (tx),
        .bit_done_o     (w_bit_done),
        .bit_pre_done_o (w_bit_pre_done)
    );

    assign req.req_ready = w_ready;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_cmd_encoder
// Description : Self-checking bench for ir_cmd_encoder with CLKS_PER_BIT=4.
//               Expected bytes are queued at acceptance; a UART monitor
//               decodes tx frames and compares them against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_cmd_encoder;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;
`ifdef IR_CMD_ENC_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int PKT_CYC = NB * FRAME_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, busy, done;

    ir_cmd_encoder_if ifc ();

    ir_cmd_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (ifc.slave),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];

    // ---------------- reference UART monitor ----------------
    logic       mon_active = 1'b0;
    int         mon_cyc;
    logic [9:0] mon_edge;
    logic [9:0] mon_mid;
    logic       mon_stable;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active  = 1'b1;
                mon_cyc     = 0;
                mon_edge    = '1;
                mon_mid     = '1;
                mon_stable  = 1'b1;
                mon_edge[0] = tx;
            end
        end else begin
            mon_cyc++;
            if (mon_cyc % CPB == 0) mon_edge[mon_cyc / CPB] = tx;
            else if (tx !== mon_edge[mon_cyc / CPB]) mon_stable = 1'b0;
            if (mon_cyc % CPB == CPB / 2) mon_mid[mon_cyc / CPB] = tx;
            if (mon_cyc == FRAME_CYC - 1) begin
                mon_active = 1'b0;
                n_checks++;
                if (mon_mid[0] !== 1'b0 || mon_mid[9] !== 1'b1 || !mon_stable) begin
                    n_fail++;
                    $display("FAIL frame_format: start=%b stop=%b stable=%b required start=0 stop=1 stable=1",
                             mon_mid[0], mon_mid[9], mon_stable);
                end
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: got byte %h, required no frame", mon_mid[8:1]);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_mid[8:1] !== mon_exp) begin
                        n_fail++;
                        $display("FAIL frame_data: got %h required %h", mon_mid[8:1], mon_exp);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_expected(input logic [2:0] c, input logic [2:0] d, input logic [7:0] a);
        logic [7:0] h;
        h = {2'b10, c, d};
        sb.push_back(h);
        sb.push_back(a);
`ifdef IR_CMD_ENC_CHECKSUM_EN
        sb.push_back(h ^ a);
`endif
    endtask

    // Presents a request and returns #1 after the accepting edge; valid stays high.
    task automatic accept_req(input logic [2:0] c, input logic [2:0] d, input logic [7:0] a);
        int n;
        @(negedge clk);
        ifc.req_valid    = 1'b1;
        ifc.req_cmd      = c;
        ifc.req_dev_addr = d;
        ifc.req_arg      = a;
        n = 0;
        while (ifc.req_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", ifc.req_ready, n);
        end
        @(posedge clk);
        #1;
        push_expected(c, d, a);
    endtask

    // Counts cycles from acceptance to the done pulse (-1 on timeout).
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < PKT_CYC + 50; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ifc.req_valid    = 1'b0;
        ifc.req_cmd      = '0;
        ifc.req_dev_addr = '0;
        ifc.req_arg      = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ifc.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
                     tx, busy, done, ifc.req_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifc.req_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b tx=%b busy=%b required 1 1 0", ifc.req_ready, tx, busy);
        end
    endtask

    task automatic test_patterns();
        logic [2:0] cs[4] = '{3'd2, 3'd4, 3'd7, 3'd5};
        logic [2:0] ds[4] = '{3'd5, 3'd5, 3'd0, 3'd7};
        logic [7:0] as[4] = '{8'h3C, 8'h3C, 8'hFF, 8'h00};
        int lat;
        for (int i = 0; i < 4; i++) begin
            accept_req(cs[i], ds[i], as[i]);
            ifc.req_valid = 1'b0;
            n_checks++;
            if (busy !== 1'b1 || tx !== 1'b0 || ifc.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL pat%0d_start: busy=%b tx=%b ready=%b required 1 0 0", i, busy, tx, ifc.req_ready);
            end
            wait_done(lat);
            n_checks++;
            if (lat != PKT_CYC) begin
                n_fail++;
                $display("FAIL pat%0d_done_latency: got %0d required %0d", i, lat, PKT_CYC);
            end
            n_checks++;
            if (busy !== 1'b0 || ifc.req_ready !== 1'b1 || sb.size() != 0) begin
                n_fail++;
                $display("FAIL pat%0d_end: busy=%b ready=%b pending=%0d required 0 1 0",
                         i, busy, ifc.req_ready, sb.size());
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL pat%0d_done_width: done=%b one cycle later, required 0", i, done);
            end
        end
    endtask

    task automatic test_capture();
        int lat;
        accept_req(3'd6, 3'd3, 8'h5A);
        ifc.req_valid = 1'b0;
        lat = -1;
        for (int n = 0; n < PKT_CYC + 50; n++) begin
            @(negedge clk);
            ifc.req_cmd      = 3'($urandom);
            ifc.req_dev_addr = 3'($urandom);
            ifc.req_arg      = 8'($urandom);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat != PKT_CYC || sb.size() != 0) begin
            n_fail++;
            $display("FAIL capture: latency=%0d pending=%0d required %0d 0", lat, sb.size(), PKT_CYC);
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        int   lat;
        accept_req(3'd3, 3'd1, 8'h81);
        ifc.req_cmd      = 3'd0;
        ifc.req_dev_addr = 3'd2;
        ifc.req_arg      = 8'h42;
        found = 1'b0;
        for (int n = 0; n < PKT_CYC + 20 && !found; n++) begin
            @(negedge clk);
            if (n == PKT_CYC - 1) begin
                n_checks++;
                if (ifc.req_ready !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_holdoff: ready=%b done=%b in last stop cycle, required 0 0",
                             ifc.req_ready, done);
                end
            end
            if (done === 1'b1) begin
                found = 1'b1;
                n_checks++;
                if (n != PKT_CYC || ifc.req_ready !== 1'b1 || tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_first_done: cycle=%0d ready=%b tx=%b required %0d 1 1",
                             n, ifc.req_ready, tx, PKT_CYC);
                end
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL b2b_first_timeout: done=0 required 1");
        end
        @(posedge clk);
        #1;
        push_expected(3'd0, 3'd2, 8'h42);
        ifc.req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: busy=%b tx=%b required 1 0", busy, tx);
        end
        wait_done(lat);
        n_checks++;
        if (lat != PKT_CYC || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_second_done: latency=%0d pending=%0d required %0d 0", lat, sb.size(), PKT_CYC);
        end
    endtask

    task automatic test_reset_mid();
        logic saw;
        int   lat;
        accept_req(3'd2, 3'd5, 8'h3C);
        ifc.req_valid = 1'b0;
        for (int n = 0; n < 25; n++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ifc.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: tx=%b busy=%b done=%b ready=%b required 1 0 0 0",
                     tx, busy, done, ifc.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < PKT_CYC; n++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL midrst_quiet: activity=1 after abandoned frame, required 0");
        end
        accept_req(3'd1, 3'd6, 8'hC3);
        ifc.req_valid = 1'b0;
        wait_done(lat);
        n_checks++;
        if (lat != PKT_CYC || sb.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_clean_packet: latency=%0d pending=%0d required %0d 0", lat, sb.size(), PKT_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
